// File: rtl/multicycle_control.sv
// Control FSM for the shared-ALU, single-memory multicycle MIPS datapath.
// Define ILLEGAL_OP_TRAP_EN to trap unknown opcodes in TRAP and add the illegal_op output.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       pcwritecond,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       irwrite,
   output logic       memtoreg,
   output logic       regdst,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       mem_err,
   output logic [3:0] state
`ifdef ILLEGAL_OP_TRAP_EN
   ,output logic      illegal_op
`endif
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
`ifdef ILLEGAL_OP_TRAP_EN
      ,TRAP   = 4'd12
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           r_state;
   state_t           w_nextState;
   logic [CNT_W-1:0] r_waitCnt;
   logic             w_memState;
   logic             w_timeout;

   assign w_memState = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
   // A ready on the last allowed cycle wins over the timeout.
   assign w_timeout  = w_memState && !mem_ready && (r_waitCnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Wait counter restarts from zero on every entry to a memory state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_waitCnt <= '0;
      end else if (!w_memState || w_timeout || (w_nextState != r_state)) begin
         r_waitCnt <= '0;
      end else if (!mem_ready) begin
         r_waitCnt <= r_waitCnt + 1'b1;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         FETCH:   w_nextState = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_RTYPE:     w_nextState = RTYPEEX;
               OP_ADDI:      w_nextState = ADDIEX;
               OP_J:         w_nextState = JEX;
               OP_BEQ:       w_nextState = BEQEX;
               OP_LW, OP_SW: w_nextState = MEMADR;
`ifdef ILLEGAL_OP_TRAP_EN
               default:      w_nextState = TRAP;
`else
               default:      w_nextState = FETCH;
`endif
            endcase
         end
         MEMADR:  w_nextState = (opcode == OP_SW) ? MEMWR : MEMRD;
         MEMRD: begin
            if (mem_ready)      w_nextState = MEMWB;
            else if (w_timeout) w_nextState = FETCH;
         end
         MEMWB:   w_nextState = FETCH;
         MEMWR: begin
            if (mem_ready || w_timeout) w_nextState = FETCH;
         end
         RTYPEEX: w_nextState = RTYPEWB;
         RTYPEWB: w_nextState = FETCH;
         BEQEX:   w_nextState = FETCH;
         ADDIEX:  w_nextState = ADDIWB;
         ADDIWB:  w_nextState = FETCH;
         JEX:     w_nextState = FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
         TRAP:    w_nextState = TRAP;
`endif
         default: w_nextState = FETCH;
      endcase
   end

   // Outputs are held at zero combinationally while reset is asserted.
   always_comb begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regdst      = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      aluop       = 2'b00;
      pcsrc       = 2'b00;
      mem_err     = 1'b0;
      state       = 4'd0;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_op  = 1'b0;
`endif
      if (!reset) begin
         state   = r_state;
         mem_err = w_timeout;
         case (r_state)
            FETCH: begin
               memread = 1'b1;
               alusrcb = 2'b01;
               irwrite = mem_ready;
               pcwrite = mem_ready;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
            end
            MEMRD: begin
               memread = 1'b1;
               iord    = 1'b1;
            end
            MEMWB: begin
               regwrite = 1'b1;
               memtoreg = 1'b1;
            end
            MEMWR: begin
               memwrite = 1'b1;
               iord     = 1'b1;
            end
            RTYPEEX: begin
               alusrca = 1'b1;
               aluop   = 2'b10;
            end
            RTYPEWB: begin
               regwrite = 1'b1;
               regdst   = 1'b1;
            end
            BEQEX: begin
               alusrca     = 1'b1;
               aluop       = 2'b01;
               pcwritecond = 1'b1;
               pcsrc       = 2'b01;
            end
            ADDIEX: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
            end
            ADDIWB:  regwrite = 1'b1;
            JEX: begin
               pcwrite = 1'b1;
               pcsrc   = 2'b10;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            TRAP:    illegal_op = 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle queues its expected outputs,
// which are popped and compared on the following falling edge.
module tb_multicycle_control;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_ADDI= 6'b001000;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BAD = 6'b111111;

   typedef struct {
      string       tag;
      logic [21:0] vec;
   } sbEntry_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
   logic       memtoreg, regdst, regwrite, alusrca, mem_err;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic [3:0] state;
   logic       illBit;

   int checks = 0;
   int errors = 0;
   sbEntry_t sbQ[$];

   multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(2)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
      .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
      .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
      .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
      .mem_err(mem_err), .state(state)
`ifdef ILLEGAL_OP_TRAP_EN
      , .illegal_op(illBit)
`endif
   );

`ifndef ILLEGAL_OP_TRAP_EN
   assign illBit = 1'b0;
`endif

   always #5 clk = ~clk;

   // Expected output vector built straight from the per-state output table.
   function automatic logic [21:0] expVec(input logic rst, input int st, input logic rdy, input logic err);
      logic pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, asa, ill;
      logic [1:0] asb, aop, psrc;
      {pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
      {asb, aop, psrc} = '0;
      if (!rst) begin
         case (st)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; io = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            11: begin pcw = 1; psrc = 2'b10; end
            12: ill = 1;
            default: ;
         endcase
      end
      return {ill, (rst ? 4'd0 : 4'(st)), pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, asa,
              asb, aop, psrc, (err & ~rst)};
   endfunction

   task automatic checkOutput(input string tag, input logic [21:0] actual, input logic [21:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h want %h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic rdy,
                                input int st, input logic err, input string tag);
      sbEntry_t e;
      reset     = rst;
      opcode    = op;
      mem_ready = rdy;
      e.tag = tag;
      e.vec = expVec(rst, st, rdy, err);
      sbQ.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (sbQ.size() > 0) begin
         sbEntry_t e;
         e = sbQ.pop_front();
         checkOutput(e.tag, {illBit, state, pcwrite, pcwritecond, iord, memread, memwrite,
                             irwrite, memtoreg, regdst, regwrite, alusrca, alusrcb, aluop,
                             pcsrc, mem_err}, e.vec);
      end
   end

   initial begin
      reset = 1'b1; opcode = OP_LW; mem_ready = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) applyStimulus(1, OP_LW, 1, 0, 0, "reset");

      // lw with no memory wait
      applyStimulus(0, OP_LW, 1, 0, 0, "lw_fetch");
      applyStimulus(0, OP_LW, 1, 1, 0, "lw_decode");
      applyStimulus(0, OP_LW, 1, 2, 0, "lw_memadr");
      applyStimulus(0, OP_LW, 1, 3, 0, "lw_memrd");
      applyStimulus(0, OP_LW, 1, 4, 0, "lw_memwb");

      // sw stalls three cycles; ready lands exactly on the last allowed cycle
      applyStimulus(0, OP_SW, 1, 0, 0, "sw_fetch");
      applyStimulus(0, OP_SW, 0, 1, 0, "sw_decode");
      applyStimulus(0, OP_SW, 0, 2, 0, "sw_memadr");
      for (int i = 0; i < 3; i++) applyStimulus(0, OP_SW, 0, 5, 0, "sw_wait");
      applyStimulus(0, OP_SW, 1, 5, 0, "sw_done");

      // fetch timeout on the 4th cycle, then retry succeeds
      for (int i = 0; i < 3; i++) applyStimulus(0, OP_BEQ, 0, 0, 0, "fetch_wait");
      applyStimulus(0, OP_BEQ, 0, 0, 1, "fetch_timeout");
      applyStimulus(0, OP_BEQ, 1, 0, 0, "fetch_retry");

      // beq then j, mem_ready ignored outside memory states
      applyStimulus(0, OP_BEQ, 0, 1, 0, "beq_decode");
      applyStimulus(0, OP_BEQ, 0, 8, 0, "beq_ex");
      applyStimulus(0, OP_J, 1, 0, 0, "j_fetch");
      applyStimulus(0, OP_J, 0, 1, 0, "j_decode");
      applyStimulus(0, OP_J, 1, 11, 0, "j_ex");

      // R-type and addi
      applyStimulus(0, OP_R, 1, 0, 0, "r_fetch");
      applyStimulus(0, OP_R, 1, 1, 0, "r_decode");
      applyStimulus(0, OP_R, 1, 6, 0, "r_ex");
      applyStimulus(0, OP_R, 1, 7, 0, "r_wb");
      applyStimulus(0, OP_ADDI, 1, 0, 0, "addi_fetch");
      applyStimulus(0, OP_ADDI, 1, 1, 0, "addi_decode");
      applyStimulus(0, OP_ADDI, 1, 9, 0, "addi_ex");
      applyStimulus(0, OP_ADDI, 1, 10, 0, "addi_wb");

      // lw whose data read times out, aborting back to fetch
      applyStimulus(0, OP_LW, 1, 0, 0, "lwto_fetch");
      applyStimulus(0, OP_LW, 1, 1, 0, "lwto_decode");
      applyStimulus(0, OP_LW, 1, 2, 0, "lwto_memadr");
      for (int i = 0; i < 3; i++) applyStimulus(0, OP_LW, 0, 3, 0, "lwto_wait");
      applyStimulus(0, OP_LW, 0, 3, 1, "lwto_timeout");

      // reset mid-instruction abandons the lw
      applyStimulus(0, OP_LW, 1, 0, 0, "mid_fetch");
      applyStimulus(0, OP_LW, 1, 1, 0, "mid_decode");
      applyStimulus(1, OP_LW, 1, 0, 0, "mid_reset");
      applyStimulus(0, OP_LW, 0, 0, 0, "mid_refetch");

      // unknown opcode
      applyStimulus(0, OP_BAD, 1, 0, 0, "bad_fetch");
      applyStimulus(0, OP_BAD, 1, 1, 0, "bad_decode");
`ifdef ILLEGAL_OP_TRAP_EN
      for (int i = 0; i < 10; i++) applyStimulus(0, OP_R, 1, 12, 0, "trap_hold");
      applyStimulus(1, OP_R, 1, 0, 0, "trap_reset");
`endif
      applyStimulus(0, OP_R, 1, 0, 0, "bad_after");

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
